// File: rtl/sparse_stream_encoder.sv
// Sparse stream encoder: turns a dense element stream into (value, index) pairs for non-zero elements.
// Latency: a pair is visible on out_valid the cycle after its element is accepted.
// Backpressure: in_ready drops when the pair buffer is full (registered occupancy); out_ready stalls the head pair.
module sparse_stream_encoder #(
   parameter int DATA_WIDTH  = 8,
   parameter int INDEX_WIDTH = 4,
   parameter int MAX_VALUES  = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          in_last,
   output logic                          in_ready,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_val,
   output logic [INDEX_WIDTH-1:0]        out_idx,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(MAX_VALUES):0]   nnz_count,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int NW = $clog2(MAX_VALUES) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [NW-1:0] NNZ_MAX = NW'(MAX_VALUES);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   val_mem [FIFO_DEPTH];
   logic [INDEX_WIDTH-1:0]  idx_mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]           cnt_q;
   logic [INDEX_WIDTH-1:0]  idx_q;
   logic [NW-1:0]           nnz_q;
   logic                    ovf_q;

   logic accept, nonzero, room, push, drop, pop, elem_last, clear;

   // Per-cycle handshake decode shared by the FSM and the datapath.
   always_comb begin
      accept    = in_valid && in_ready;
      nonzero   = (in_data != '0);
      room      = (nnz_q < NNZ_MAX);
      push      = accept && nonzero && room;
      drop      = accept && nonzero && !room;
      pop       = out_valid && out_ready;
      // The last slot of the index space ends the vector even without in_last.
      elem_last = in_last || (idx_q == '1);
      clear     = (state_q == IDLE) && start;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (accept && elem_last) state_d = DRAIN;
         DRAIN:   if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs; in_ready uses only the registered occupancy so a same-cycle pop never opens the gate.
   always_comb begin
      in_ready  = (state_q == SCAN) && (cnt_q < DEPTH_C);
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      out_valid = (cnt_q != '0);
      out_val   = out_valid ? val_mem[rd_ptr_q] : '0;
      out_idx   = out_valid ? idx_mem[rd_ptr_q] : '0;
      nnz_count = nnz_q;
      overflow  = ovf_q;
   end

   // Pair buffer storage; contents are don't-care while the slot is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         val_mem[wr_ptr_q] <= in_data;
         idx_mem[wr_ptr_q] <= idx_q;
      end
   end

   // Pair buffer pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Element index, pair count and sticky drop flag; cleared on an honoured start.
   // The index may roll to 0 after the final slot, but the FSM has already left SCAN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         nnz_q <= '0;
         ovf_q <= 1'b0;
      end else if (clear) begin
         idx_q <= '0;
         nnz_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (accept) idx_q <= idx_q + 1'b1;
         if (push)   nnz_q <= nnz_q + 1'b1;
         if (drop)   ovf_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sparse_stream_encoder.sv
// Directed bench for sparse_stream_encoder: default instance plus a MAX_VALUES=2 instance on shared inputs.
// Pairs leaving each instance are logged by a monitor and compared against hand-computed lists.
// Every wait on the design is bounded; an expired bound is reported as a miscompare.
module tb_sparse_stream_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;

   logic       a_in_ready, a_out_valid, a_busy, a_done, a_overflow;
   logic [7:0] a_out_val;
   logic [3:0] a_out_idx;
   logic [4:0] a_nnz;
   logic       b_in_ready, b_out_valid, b_busy, b_done, b_overflow;
   logic [7:0] b_out_val;
   logic [3:0] b_out_idx;
   logic [1:0] b_nnz;

   int n_vec = 0;
   int n_err = 0;
   logic [11:0] a_q[$];
   logic [11:0] b_q[$];
   int a_vld_cnt = 0;
   int b_done_cnt = 0;

   always #5 clk = ~clk;

   sparse_stream_encoder u_a (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(a_in_ready), .out_valid(a_out_valid), .out_val(a_out_val),
      .out_idx(a_out_idx), .out_ready(out_ready), .busy(a_busy), .done(a_done),
      .nnz_count(a_nnz), .overflow(a_overflow));

   sparse_stream_encoder #(.MAX_VALUES(2)) u_b (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(b_in_ready), .out_valid(b_out_valid), .out_val(b_out_val),
      .out_idx(b_out_idx), .out_ready(out_ready), .busy(b_busy), .done(b_done),
      .nnz_count(b_nnz), .overflow(b_overflow));

   // Log every pair that leaves each instance, in order.
   always @(posedge clk) begin
      if (a_out_valid && out_ready) a_q.push_back({a_out_val, a_out_idx});
      if (b_out_valid && out_ready) b_q.push_back({b_out_val, b_out_idx});
      if (a_out_valid) a_vld_cnt <= a_vld_cnt + 1;
      if (b_done) b_done_cnt <= b_done_cnt + 1;
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Present one element and hold it until accepted.
   task automatic send(input logic [7:0] d, input logic l);
      int t;
      in_valid = 1'b1; in_data = d; in_last = l; t = 0;
      while (!a_in_ready && t < 50) begin @(posedge clk); #1; t++; end
      n_vec++;
      if (a_in_ready !== 1'b1) begin
         n_err++; $display("FAIL send_accept data=%0d in_ready=%b required 1", d, a_in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
   endtask

   // Wait for done, then confirm it is a single-cycle pulse back to IDLE.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!a_done && cyc < 200) begin @(posedge clk); #1; cyc++; end
      n_vec++;
      if (a_done !== 1'b1) begin n_err++; $display("FAIL done_seen done=%b required 1", a_done); end
      @(posedge clk); #1;
      n_vec++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) begin
         n_err++; $display("FAIL done_pulse done=%b busy=%b required 0 0", a_done, a_busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({a_in_ready, a_out_valid, a_out_val, a_out_idx, a_busy, a_done, a_nnz, a_overflow} !== 23'd0) begin
         n_err++; $display("FAIL reset_outputs got rdy=%b vld=%b val=%0d idx=%0d busy=%b done=%b nnz=%0d ovf=%b required all 0",
                           a_in_ready, a_out_valid, a_out_val, a_out_idx, a_busy, a_done, a_nnz, a_overflow);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy=%b required 0", a_busy); end
   endtask

   task automatic test_basic();
      int base, cyc;
      base = a_q.size();
      out_ready = 1'b1;
      pulse_start();
      n_vec++;
      if (a_busy !== 1'b1 || a_in_ready !== 1'b1) begin
         n_err++; $display("FAIL basic_scan busy=%b in_ready=%b required 1 1", a_busy, a_in_ready);
      end
      send(8'd0, 1'b0);
      n_vec++;
      if (a_out_valid !== 1'b0 || a_out_val !== 8'd0 || a_out_idx !== 4'd0) begin
         n_err++; $display("FAIL basic_zero_idle vld=%b val=%0d idx=%0d required 0 0 0", a_out_valid, a_out_val, a_out_idx);
      end
      send(8'd5, 1'b0);
      n_vec++;
      if (a_out_valid !== 1'b1 || a_out_val !== 8'd5 || a_out_idx !== 4'd1) begin
         n_err++; $display("FAIL basic_latency vld=%b val=%0d idx=%0d required 1 5 1", a_out_valid, a_out_val, a_out_idx);
      end
      send(8'd0, 1'b0);
      send(8'd7, 1'b1);
      n_vec++;
      if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL basic_drain_rdy in_ready=%b required 0", a_in_ready); end
      wait_done(cyc);
      n_vec++;
      if (cyc !== 2) begin n_err++; $display("FAIL basic_done_cycle got %0d cycles required 2", cyc); end
      n_vec++;
      if (a_q.size() - base !== 2 || a_q[base] !== {8'd5, 4'd1} || a_q[base+1] !== {8'd7, 4'd3}) begin
         n_err++; $display("FAIL basic_pairs count=%0d required 2 with (5,1),(7,3)", a_q.size() - base);
      end
      n_vec++;
      if (a_nnz !== 5'd2 || a_overflow !== 1'b0) begin
         n_err++; $display("FAIL basic_counts nnz=%0d ovf=%b required 2 0", a_nnz, a_overflow);
      end
   endtask

   task automatic test_zeros();
      int base, vbase, cyc;
      base = a_q.size(); vbase = a_vld_cnt;
      out_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 4; i++) send(8'd0, i == 3);
      wait_done(cyc);
      n_vec++;
      if (a_vld_cnt - vbase !== 0 || a_q.size() - base !== 0) begin
         n_err++; $display("FAIL zeros_no_output valid_cycles=%0d required 0", a_vld_cnt - vbase);
      end
      n_vec++;
      if (a_nnz !== 5'd0 || a_overflow !== 1'b0) begin
         n_err++; $display("FAIL zeros_counts nnz=%0d ovf=%b required 0 0", a_nnz, a_overflow);
      end
   endtask

   task automatic test_backpressure();
      int base, cyc;
      base = a_q.size();
      out_ready = 1'b0;
      pulse_start();
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
      in_valid = 1'b1; in_data = 8'd5; in_last = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_val !== 8'd1 || a_out_idx !== 4'd0) begin
            n_err++; $display("FAIL bp_hold cyc=%0d rdy=%b vld=%b val=%0d idx=%0d required 0 1 1 0",
                              k, a_in_ready, a_out_valid, a_out_val, a_out_idx);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_pop_same_cycle in_ready=%b required 0", a_in_ready); end
      send(8'd5, 1'b1);
      wait_done(cyc);
      n_vec++;
      if (a_q.size() - base !== 5) begin
         n_err++; $display("FAIL bp_count got %0d pairs required 5", a_q.size() - base);
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (a_q[base+i] !== {8'(i + 1), 4'(i)}) begin
               n_err++; $display("FAIL bp_order pos=%0d got %h required %h", i, a_q[base+i], {8'(i + 1), 4'(i)});
            end
         end
      end
   endtask

   task automatic test_overflow();
      int base_a, base_b, dbase, cyc;
      base_a = a_q.size(); base_b = b_q.size(); dbase = b_done_cnt;
      out_ready = 1'b1;
      pulse_start();
      send(8'd3, 1'b0); send(8'd0, 1'b0); send(8'd4, 1'b0); send(8'd6, 1'b1);
      wait_done(cyc);
      n_vec++;
      if (b_q.size() - base_b !== 2 || b_q[base_b] !== {8'd3, 4'd0} || b_q[base_b+1] !== {8'd4, 4'd2}) begin
         n_err++; $display("FAIL ovf_pairs count=%0d required 2 with (3,0),(4,2)", b_q.size() - base_b);
      end
      n_vec++;
      if (b_overflow !== 1'b1 || b_nnz !== 2'd2) begin
         n_err++; $display("FAIL ovf_flags ovf=%b nnz=%0d required 1 2", b_overflow, b_nnz);
      end
      n_vec++;
      if (b_done_cnt - dbase !== 1 || b_busy !== 1'b0 || b_in_ready !== 1'b0) begin
         n_err++; $display("FAIL ovf_done done_pulses=%0d busy=%b rdy=%b required 1 0 0", b_done_cnt - dbase, b_busy, b_in_ready);
      end
      n_vec++;
      if (a_overflow !== 1'b0 || a_nnz !== 5'd3 || a_q.size() - base_a !== 3) begin
         n_err++; $display("FAIL ovf_default ovf=%b nnz=%0d pairs=%0d required 0 3 3", a_overflow, a_nnz, a_q.size() - base_a);
      end
   endtask

   task automatic test_implicit_last();
      int base, cyc;
      base = a_q.size();
      out_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         if (i == 5) start = 1'b1;
         send(8'(i), 1'b0);
         start = 1'b0;
         if (i == 5) begin
            n_vec++;
            if (a_busy !== 1'b1) begin n_err++; $display("FAIL il_start_ignored busy=%b required 1", a_busy); end
         end
      end
      n_vec++;
      if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
         n_err++; $display("FAIL il_drain rdy=%b busy=%b required 0 1", a_in_ready, a_busy);
      end
      wait_done(cyc);
      n_vec++;
      if (a_nnz !== 5'd15 || a_q.size() - base !== 15) begin
         n_err++; $display("FAIL il_count nnz=%0d pairs=%0d required 15 15", a_nnz, a_q.size() - base);
      end else begin
         for (int i = 0; i < 15; i++) begin
            n_vec++;
            if (a_q[base+i] !== {8'(i + 1), 4'(i + 1)}) begin
               n_err++; $display("FAIL il_pair pos=%0d got %h required %h", i, a_q[base+i], {8'(i + 1), 4'(i + 1)});
            end
         end
      end
   endtask

   task automatic test_reset_midscan();
      int base, cyc;
      out_ready = 1'b0;
      pulse_start();
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      n_vec++;
      if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL rm_buffered vld=%b required 1", a_out_valid); end
      rst = 1'b1;
      #1;
      n_vec++;
      if ({a_in_ready, a_out_valid, a_out_val, a_out_idx, a_busy, a_done, a_nnz, a_overflow} !== 23'd0) begin
         n_err++; $display("FAIL rm_outputs rdy=%b vld=%b val=%0d idx=%0d busy=%b done=%b nnz=%0d ovf=%b required all 0",
                           a_in_ready, a_out_valid, a_out_val, a_out_idx, a_busy, a_done, a_nnz, a_overflow);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      base = a_q.size();
      out_ready = 1'b1;
      pulse_start();
      send(8'd9, 1'b1);
      wait_done(cyc);
      n_vec++;
      if (a_q.size() - base !== 1 || a_q[base] !== {8'd9, 4'd0}) begin
         n_err++; $display("FAIL rm_restart pairs=%0d required 1 with (9,0)", a_q.size() - base);
      end
      n_vec++;
      if (a_nnz !== 5'd1) begin n_err++; $display("FAIL rm_nnz nnz=%0d required 1", a_nnz); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zeros();
      test_backpressure();
      test_overflow();
      test_implicit_last();
      test_reset_midscan();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sparse_stream_encoder.md
SPARSE_STREAM_ENCODER -- requirements
Module: sparse_stream_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per element.
REQ-002 SHALL have parameter INDEX_WIDTH, default 4, bits per element index; a vector holds at most 2^INDEX_WIDTH elements.
REQ-003 SHALL have parameter MAX_VALUES, default 16, maximum non-zero pairs emitted per vector.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output pair buffer depth (power of 2, >=2).
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  begin a new vector; honoured only in IDLE.
REQ-008 in_valid  input  1  dense element present.
REQ-009 in_data  input  DATA_WIDTH  dense element value.
REQ-010 in_last  input  1  final element of vector, qualified by in_valid.
REQ-011 in_ready  output  1  encoder accepts element this cycle.
REQ-012 out_valid  output  1  pair available.
REQ-013 out_val  output  DATA_WIDTH  non-zero value of head pair.
REQ-014 out_idx  output  INDEX_WIDTH  position of head pair within vector.
REQ-015 out_ready  input  1  consumer accepts pair.
REQ-016 busy  output  1  state != IDLE.
REQ-017 done  output  1  one-cycle pulse at end of vector.
REQ-018 nnz_count  output  $clog2(MAX_VALUES)+1  pairs pushed this vector.
REQ-019 overflow  output  1  sticky: a non-zero was dropped this vector.

Function
REQ-020 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-021 IDLE: in_ready=0; start=1 -> SCAN next cycle; same edge clears element index, nnz_count, overflow.
REQ-022 SCAN: in_ready = (FIFO occupancy < FIFO_DEPTH), from registered occupancy only; a pop in the same cycle does not raise in_ready.
REQ-023 Element accepted when in_valid && in_ready; element index increments by 1 per accepted element, starting at 0.
REQ-024 Accepted element with in_data != 0 and nnz_count < MAX_VALUES: push (in_data, index), nnz_count +1.
REQ-025 Accepted element with in_data != 0 and nnz_count == MAX_VALUES: drop it, set overflow=1 until next start or reset.
REQ-026 Accepted element with in_data == 0: no push; index still advances.
REQ-027 SCAN -> DRAIN on accepting an element with in_last=1, or on accepting the element at index 2^INDEX_WIDTH-1 (implicit last; index never wraps).
REQ-028 DRAIN: in_ready=0; -> DONE the cycle after FIFO occupancy is 0.
REQ-029 DONE: done=1 for exactly that cycle; -> IDLE next cycle; nnz_count and overflow hold until next start.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 out_valid = FIFO non-empty; out_val/out_idx = head entry; pop on out_valid && out_ready.
REQ-032 Pairs SHALL leave in acceptance order; first pair visible on out_valid the cycle after its element is accepted (latency 1).
REQ-033 While out_valid=1 and out_ready=0, out_val/out_idx SHALL stay stable.
REQ-034 Simultaneous push and pop in one cycle SHALL leave occupancy unchanged and lose no data.
REQ-035 out_val/out_idx SHALL be 0 when out_valid=0.

Reset
REQ-036 rst=1 at any time, including mid-SCAN or mid-DRAIN, SHALL force IDLE, empty FIFO, index 0, and in_ready, out_valid, out_val, out_idx, busy, done, nnz_count, overflow all 0; buffered pairs are discarded.
REQ-037 First start after reset release SHALL be honoured normally.

Verification
REQ-038 start; out_ready=1; stream 0,5,0,7 (last on 7) -> pairs (5,1),(7,3); nnz_count=2; overflow=0; done one pulse after second pair leaves.
REQ-039 start; stream 0,0,0,0 (last on 4th) -> out_valid never 1; nnz_count=0; done pulses.
REQ-040 out_ready=0; stream 1,2,3,4,5 all valid -> in_ready=0 after 4 accepted, out (1,0) held stable; out_ready=1 -> (1,0),(2,1),(3,2),(4,3),(5,4) in order, done after last.
REQ-041 MAX_VALUES=2; stream 3,0,4,6 (last) -> pairs (3,0),(4,2); overflow=1; nnz_count=2.
REQ-042 Stream 16 elements, none with in_last -> DRAIN after index 15; start pulsed mid-SCAN ignored (busy stays 1, index unaffected).
REQ-043 rst asserted mid-SCAN with 2 pairs buffered -> all outputs 0 immediately; new start and stream 9 (last) -> single pair (9,0).
